// File: rtl/cache_pkg.sv
// Shared cache definitions: FSM state encoding and block geometry constants.
// Latency: none, this file holds only types, constants and a helper function.
// Backpressure: none, this file has no handshake.
package cache_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MEM_READ = 2'd1,
      UPDATE   = 2'd2
   } cache_state_t;

   localparam int WORDS      = 4;
   localparam int WORD_W     = 32;
   localparam int BLOCK_W    = WORDS * WORD_W;
   localparam int BLK_ADDR_W = 28;   // address[31:4]

   // Pick one 32-bit word out of a block; word 0 sits in the low bits.
   function automatic logic [WORD_W-1:0] select_word(input logic [BLOCK_W-1:0] blk,
                                                     input logic [1:0]         word);
      return blk[word*WORD_W +: WORD_W];
   endfunction

endpackage

// File: rtl/instruction_cache_if.sv
// Fetch-side and memory-side signals of the instruction cache, bundled together.
// Latency: none, this is wiring only.
// Backpressure: busywait stalls the fetch unit; mem_busywait stalls the cache.
interface instruction_cache_if;
   import cache_pkg::*;

   logic                  read;
   logic [31:0]           address;
   logic                  flush;
   logic [WORD_W-1:0]     instruction;
   logic                  busywait;
   logic                  mem_read;
   logic [BLK_ADDR_W-1:0] mem_address;
   logic [BLOCK_W-1:0]    mem_readdata;
   logic                  mem_busywait;

   // The cache side.
   modport slave (
      input  read, address, flush, mem_readdata, mem_busywait,
      output instruction, busywait, mem_read, mem_address
   );

   // The fetch unit and memory side.
   modport master (
      output read, address, flush, mem_readdata, mem_busywait,
      input  instruction, busywait, mem_read, mem_address
   );
endinterface

// File: rtl/cache_line_array.sv
// Valid/tag/block storage for a direct-mapped cache, with a bulk invalidate.
// Latency: the read port is combinational; writes and invalidation land on the next edge.
// Backpressure: none, the array accepts a write or invalidate in every cycle.
module cache_line_array
   import cache_pkg::*;
#(
   parameter  int LINES = 8,
   localparam int IDX_W = $clog2(LINES),
   localparam int TAG_W = BLK_ADDR_W - IDX_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [IDX_W-1:0]   rd_index,
   output logic               rd_valid,
   output logic [TAG_W-1:0]   rd_tag,
   output logic [BLOCK_W-1:0] rd_block,
   input  logic               wr_en,
   input  logic [IDX_W-1:0]   wr_index,
   input  logic [TAG_W-1:0]   wr_tag,
   input  logic [BLOCK_W-1:0] wr_block,
   input  logic               invalidate_all
);

   logic [LINES-1:0]   valid_q;
   logic [TAG_W-1:0]   tag_q  [LINES];
   logic [BLOCK_W-1:0] data_q [LINES];

   // Valid bits: invalidation wins over a simultaneous fill of the same line.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
      end else if (invalidate_all) begin
         valid_q <= '0;
      end else if (wr_en) begin
         valid_q[wr_index] <= 1'b1;
      end
   end

   // Tag and block storage; contents are meaningless until the valid bit is set.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_q[wr_index]  <= wr_tag;
         data_q[wr_index] <= wr_block;
      end
   end

   assign rd_valid = valid_q[rd_index];
   assign rd_tag   = tag_q[rd_index];
   assign rd_block = data_q[rd_index];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache with whole-block refill and flush.
// Latency: a hit returns data in the same cycle; a miss stalls for M+3 cycles.
// Backpressure: busywait holds the fetch unit; mem_busywait holds the refill in MEM_READ.
module instruction_cache
   import cache_pkg::*;
#(
   parameter int LINES = 8
) (
   input  logic                clk,
   input  logic                reset,
   instruction_cache_if.slave  bus
);

   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = BLK_ADDR_W - IDX_W;

   cache_state_t          state_q, state_d;
   logic [BLK_ADDR_W-1:0] blk_addr_q;
   logic [BLOCK_W-1:0]    fill_q;
   logic                  flush_pend_q;

   logic [BLK_ADDR_W-1:0] blk_addr;
   logic [IDX_W-1:0]      index;
   logic [TAG_W-1:0]      tag;
   logic                  rd_valid;
   logic [TAG_W-1:0]      rd_tag;
   logic [BLOCK_W-1:0]    rd_block;
   logic                  hit;
   logic                  invalidate_all;

   assign blk_addr = bus.address[31:4];
   assign index    = blk_addr[IDX_W-1:0];
   assign tag      = blk_addr[BLK_ADDR_W-1:IDX_W];

   // Only meaningful in IDLE; the FSM ignores it elsewhere.
   assign hit = bus.read && rd_valid && (rd_tag == tag);

   // A flush seen in IDLE applies at once; one seen mid-refill waits for UPDATE,
   // so the freshly written line is dropped as well.
   assign invalidate_all = ((state_q == IDLE) && bus.flush) ||
                           ((state_q == UPDATE) && (flush_pend_q || bus.flush));

   cache_line_array #(.LINES(LINES)) u_lines (
      .clk            (clk),
      .reset          (reset),
      .rd_index       (index),
      .rd_valid       (rd_valid),
      .rd_tag         (rd_tag),
      .rd_block       (rd_block),
      .wr_en          (state_q == UPDATE),
      .wr_index       (blk_addr_q[IDX_W-1:0]),
      .wr_tag         (blk_addr_q[BLK_ADDR_W-1:IDX_W]),
      .wr_block       (fill_q),
      .invalidate_all (invalidate_all)
   );

   // State register and the pending-flush flag; reset abandons any refill in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         flush_pend_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == UPDATE) begin
            flush_pend_q <= 1'b0;
         end else if ((state_q == MEM_READ) && bus.flush) begin
            flush_pend_q <= 1'b1;
         end
      end
   end

   // Latch the block address on entering MEM_READ and capture the refill data
   // in the cycle memory drops its busy.
   always_ff @(posedge clk) begin
      if ((state_q == IDLE) && (state_d == MEM_READ)) begin
         blk_addr_q <= blk_addr;
      end
      if ((state_q == MEM_READ) && !bus.mem_busywait) begin
         fill_q <= bus.mem_readdata;
      end
   end

   // Next-state and output decode.
   always_comb begin
      state_d         = state_q;
      bus.busywait    = 1'b0;
      bus.instruction = '0;
      bus.mem_read    = 1'b0;
      bus.mem_address = '0;
      case (state_q)
         IDLE: begin
            if (hit) begin
               bus.instruction = select_word(rd_block, bus.address[3:2]);
            end else if (bus.read) begin
               bus.busywait = 1'b1;
               state_d      = MEM_READ;
            end
         end
         MEM_READ: begin
            bus.busywait    = 1'b1;
            bus.mem_read    = 1'b1;
            bus.mem_address = blk_addr_q;
            if (!bus.mem_busywait) begin
               state_d = UPDATE;
            end
         end
         UPDATE: begin
            bus.busywait = 1'b1;
            state_d      = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache with a latency-programmable memory model.
// Latency: the memory holds mem_busywait high for lat cycles after mem_read rises.
// Backpressure: the fetch side holds address and read until busywait drops.
module tb_instruction_cache;
   import cache_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   instruction_cache_if bus();

   instruction_cache #(.LINES(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   int          lat      = 3;
   int          cnt      = 0;
   int          refills  = 0;
   logic        mem_read_prev = 1'b0;
   logic        addr_leak     = 1'b0;
   logic [27:0] last_mem_addr = '0;

   // Memory contents: word k of block b is ((b - 4) << 4) + k + 1,
   // so block 0x4 holds {4,3,2,1} and block 0xC holds {0x84..0x81}.
   function automatic logic [31:0] mem_word(input logic [27:0] b, input int k);
      return ((32'(b) - 32'd4) << 4) + 32'(k) + 32'd1;
   endfunction

   assign bus.mem_readdata = {mem_word(bus.mem_address, 3), mem_word(bus.mem_address, 2),
                              mem_word(bus.mem_address, 1), mem_word(bus.mem_address, 0)};
   assign bus.mem_busywait = bus.mem_read && (cnt < lat);

   // Memory latency counter and refill counter (rising edges of mem_read).
   always @(posedge clk) begin
      if (!bus.mem_read) cnt <= 0;
      else               cnt <= cnt + 1;
      if (bus.mem_read && !mem_read_prev) refills <= refills + 1;
      mem_read_prev <= bus.mem_read;
   end

   // Record the refill address and catch a nonzero mem_address outside a refill.
   always @(negedge clk) begin
      if (bus.mem_read) last_mem_addr <= bus.mem_address;
      else if (bus.mem_address != '0) addr_leak <= 1'b1;
   end

   // Issue one fetch and wait for busywait to drop; stalls = -1 on timeout.
   // flush is raised for the single cycle with index flush_at.
   task automatic do_fetch(input logic [31:0] a, input int flush_at,
                           output int stalls, output logic [31:0] instr);
      @(posedge clk); #1;
      bus.read    = 1'b1;
      bus.address = a;
      stalls      = -1;
      instr       = 32'hDEAD_BEEF;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         bus.flush = (c == flush_at);
         if (!bus.busywait) begin
            stalls = c;
            instr  = bus.instruction;
            break;
         end
      end
      @(posedge clk); #1;
      bus.flush = 1'b0;
      bus.read  = 1'b0;
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      bus.read = 1'b0; bus.address = '0; bus.flush = 1'b0;
      pulse_reset();
      @(negedge clk);
      n_checks++;
      if (bus.busywait !== 1'b0) begin n_fail++; $display("FAIL reset_busywait got %b want 0", bus.busywait); end
      n_checks++;
      if (bus.mem_read !== 1'b0) begin n_fail++; $display("FAIL reset_mem_read got %b want 0", bus.mem_read); end
      n_checks++;
      if (bus.instruction !== 32'h0) begin n_fail++; $display("FAIL reset_instruction got %h want 0", bus.instruction); end
      n_checks++;
      if (bus.mem_address !== 28'h0) begin n_fail++; $display("FAIL reset_mem_address got %h want 0", bus.mem_address); end
   endtask

   task automatic test_cold_miss();
      int s; logic [31:0] ins; int r0;
      lat = 3;
      r0  = refills;
      do_fetch(32'h0000_0040, -1, s, ins);
      n_checks++;
      if (s !== 6) begin n_fail++; $display("FAIL cold_stall got %0d want 6", s); end
      n_checks++;
      if (ins !== 32'h1) begin n_fail++; $display("FAIL cold_data got %h want 1", ins); end
      n_checks++;
      if (last_mem_addr !== 28'h4) begin n_fail++; $display("FAIL cold_mem_address got %h want 4", last_mem_addr); end
      n_checks++;
      if (refills - r0 !== 1) begin n_fail++; $display("FAIL cold_refills got %0d want 1", refills - r0); end
   endtask

   task automatic test_same_block_hits();
      int s; logic [31:0] ins; int r0;
      logic [31:0] addrs [3] = '{32'h44, 32'h48, 32'h4C};
      logic [31:0] want  [3] = '{32'h2, 32'h3, 32'h4};
      r0 = refills;
      for (int i = 0; i < 3; i++) begin
         do_fetch(addrs[i], -1, s, ins);
         n_checks++;
         if (s !== 0) begin n_fail++; $display("FAIL hit_stall[%0d] got %0d want 0", i, s); end
         n_checks++;
         if (ins !== want[i]) begin n_fail++; $display("FAIL hit_data[%0d] got %h want %h", i, ins, want[i]); end
      end
      n_checks++;
      if (refills !== r0) begin n_fail++; $display("FAIL hit_no_refill got %0d want %0d", refills, r0); end
   endtask

   task automatic test_conflict();
      int s; logic [31:0] ins; int r0;
      logic [31:0] addrs [3] = '{32'h40, 32'hC0, 32'h40};
      logic [31:0] want  [3] = '{32'h1, 32'h81, 32'h1};
      pulse_reset();
      lat = 3;
      for (int i = 0; i < 3; i++) begin
         r0 = refills;
         do_fetch(addrs[i], -1, s, ins);
         n_checks++;
         if (s !== 6) begin n_fail++; $display("FAIL conflict_stall[%0d] got %0d want 6", i, s); end
         n_checks++;
         if (ins !== want[i]) begin n_fail++; $display("FAIL conflict_data[%0d] got %h want %h", i, ins, want[i]); end
         n_checks++;
         if (refills - r0 !== 1) begin n_fail++; $display("FAIL conflict_refills[%0d] got %0d want 1", i, refills - r0); end
      end
   endtask

   task automatic test_flush();
      int s; logic [31:0] ins; int r0;
      // 0x40 is warm: the fetch in the flush cycle still hits the old contents.
      do_fetch(32'h40, 0, s, ins);
      n_checks++;
      if (s !== 0 || ins !== 32'h1) begin n_fail++; $display("FAIL flush_same_cycle got stall %0d data %h want 0/1", s, ins); end
      r0 = refills;
      do_fetch(32'h40, -1, s, ins);
      n_checks++;
      if (s !== 6 || ins !== 32'h1) begin n_fail++; $display("FAIL flush_idle_refetch got stall %0d data %h want 6/1", s, ins); end
      n_checks++;
      if (refills - r0 !== 1) begin n_fail++; $display("FAIL flush_idle_refills got %0d want 1", refills - r0); end
      // 0xC0 was evicted: flush in MEM_READ forces a second refill.
      r0 = refills;
      do_fetch(32'hC0, 1, s, ins);
      n_checks++;
      if (s !== 12 || ins !== 32'h81) begin n_fail++; $display("FAIL flush_midrefill got stall %0d data %h want 12/81", s, ins); end
      n_checks++;
      if (refills - r0 !== 2) begin n_fail++; $display("FAIL flush_midrefill_refills got %0d want 2", refills - r0); end
   endtask

   task automatic test_reset_mid_refill();
      int s; logic [31:0] ins;
      lat = 3;
      @(posedge clk); #1;
      bus.read    = 1'b1;
      bus.address = 32'h200;
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (bus.mem_read !== 1'b1) begin n_fail++; $display("FAIL midrst_in_mem_read got %b want 1", bus.mem_read); end
      reset    = 1'b1;
      bus.read = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      n_checks++;
      if (bus.mem_read !== 1'b0 || bus.busywait !== 1'b0 || bus.instruction !== 32'h0)
         begin n_fail++; $display("FAIL midrst_outputs got mem_read %b busywait %b instr %h want 0/0/0",
                                  bus.mem_read, bus.busywait, bus.instruction); end
      do_fetch(32'h40, -1, s, ins);
      n_checks++;
      if (s !== 6 || ins !== 32'h1) begin n_fail++; $display("FAIL midrst_refetch got stall %0d data %h want 6/1", s, ins); end
      do_fetch(32'h200, -1, s, ins);
      n_checks++;
      if (s !== 6 || ins !== 32'h1C1) begin n_fail++; $display("FAIL midrst_other got stall %0d data %h want 6/1c1", s, ins); end
   endtask

   task automatic test_zero_latency();
      int s; logic [31:0] ins;
      lat = 0;
      do_fetch(32'h100, -1, s, ins);
      n_checks++;
      if (s !== 3 || ins !== 32'hC1) begin n_fail++; $display("FAIL zero_lat got stall %0d data %h want 3/c1", s, ins); end
      do_fetch(32'h10C, -1, s, ins);
      n_checks++;
      if (s !== 0 || ins !== 32'hC4) begin n_fail++; $display("FAIL zero_lat_hit got stall %0d data %h want 0/c4", s, ins); end
   endtask

   initial begin
      reset       = 1'b1;
      bus.read    = 1'b0;
      bus.address = '0;
      bus.flush   = 1'b0;
      test_reset();
      test_cold_miss();
      test_same_block_hits();
      test_conflict();
      test_flush();
      test_reset_mid_refill();
      test_zero_latency();
      n_checks++;
      if (addr_leak !== 1'b0) begin n_fail++; $display("FAIL mem_address_idle got nonzero want 0"); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instruction_cache.md
# instruction_cache

Direct-mapped, read-only instruction cache between the instruction fetch unit and the instruction memory. Serves 32-bit fetches from a local block array, stalls the fetch unit through `busywait` on a miss, and refills a whole block from memory. A `flush` input invalidates all lines so the cache can be emptied on an OS context switch.

## Interface
- `LINES`, 8: number of cache lines; power of two, at least 2.
- `WORDS`, 4: 32-bit words per block, fixed at 4 (128-bit block).
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `read`  in  1  fetch request valid.
- `address`  in  32  byte address of the fetch (PC).
- `flush`  in  1  one-cycle pulse that invalidates all lines.
- `instruction`  out  32  fetched word.
- `busywait`  out  1  stall to the fetch unit.
- `mem_read`  out  1  refill request to instruction memory.
- `mem_address`  out  28  block address, `address[31:4]`.
- `mem_readdata`  in  128  refill block; word 0 is in `[31:0]`.
- `mem_busywait`  in  1  memory is busy; data is valid in the cycle it drops.

## Operation
- Address split: offset `[1:0]` is ignored; word `[3:2]`; index `[3+log2(LINES):4]`; tag is the remaining upper bits (25 bits when LINES=8).
- Per line: a valid bit, a tag, and a 128-bit block.
- Hit = `read` & valid[index] & (tag[index] == addr tag), evaluated combinationally in IDLE.
- Hit output: `instruction` = the selected word, `busywait` = 0.
- Miss output: `busywait` = 1. `instruction` = 32'h0 whenever `busywait` = 1 or `read` = 0.
- FSM states:
  - IDLE: on `read` & !hit, go to MEM_READ.
  - MEM_READ: `mem_read` = 1 and `mem_address` = `address[31:4]`. Stay while `mem_busywait` = 1. When it is 0, go to UPDATE.
  - UPDATE: write the block, tag and valid bit = 1. Go to IDLE. The access then hits in the next cycle.
- `busywait` = 1 for the whole of MEM_READ and UPDATE.
- `mem_read` = 0 and `mem_address` = 0 outside MEM_READ.
- `address` is held stable by the stalled fetch unit during a miss. The refill must use the block address that was latched on entry to MEM_READ.
- Flush:
  - In IDLE, all valid bits clear at the next edge. A fetch in that same cycle is evaluated against the pre-flush contents.
  - During MEM_READ or UPDATE, flush is latched as pending. All valid bits clear on the UPDATE edge, including the line being refilled. The re-check in IDLE then misses and refetches.
- Reset, at any state including mid-refill: state = IDLE, all valid bits = 0, pending flush = 0, `mem_read` = 0, `busywait` = 0 (with `read` = 0), `instruction` = 0. A memory response still in flight is ignored.

## Timing
- Hit: 0-cycle latency; data is combinational in the same cycle.
- Miss with memory latency M (cycles with `mem_busywait` high after `mem_read` rises):
  - Cycle 0: IDLE detects the miss.
  - Cycles 1..M+1: MEM_READ.
  - Cycle M+2: UPDATE.
  - Cycle M+3: hit, `busywait` = 0.
- Total stall is M+3 cycles.
- M = 0 is legal: a single MEM_READ cycle in which `mem_busywait` is already low.

## Structure
- Shared package (`cache_pkg`) holds the FSM state encoding (IDLE/MEM_READ/UPDATE) and the `WORDS`/block-width constants. A future data cache will reuse it.
- One sub-module: `cache_line_array`. It holds the valid/tag/data storage and takes LINES as a parameter. It provides:
  - a combinational read port (index → valid, tag, block);
  - a synchronous write port (index, tag, block);
  - a one-cycle `invalidate_all`.
- The FSM, hit logic and word select live in `instruction_cache`.

## Test plan
- Cold miss: reset, then `read` = 1, `address` = 0x0000_0040, memory latency 3, block = {0x4,0x3,0x2,0x1} → `busywait` high for 6 cycles, `mem_address` = 0x0000004, then `instruction` = 0x1.
- Same-block hits: after the above, addresses 0x44/0x48/0x4C → 0x2/0x3/0x4 with `busywait` = 0 and no `mem_read`.
- Conflict: fetch 0x40, then 0x0000_00C0 (same index 4, different tag), then 0x40 → three misses and three refills; each returns the correct block word 0.
- Flush: warm 0x40, pulse `flush` in IDLE, fetch 0x40 → miss with a refill. Pulse `flush` during MEM_READ → the refill completes, the re-check misses, and a second refill occurs.
- Reset mid-refill: assert `reset` in MEM_READ → next cycle `mem_read` = 0 and state IDLE. A fetch of the same address then misses.
- Zero-latency memory (`mem_busywait` never high) → stall of 3 cycles, correct data.
